// File: rtl/ooc_util_pkg.sv
// Shared helpers for the out-of-context harness blocks: shifter states,
// default polynomials and the bus-to-signature XOR fold.
package ooc_util_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_e;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [15:0] CRC16_POLY = 16'h8005;

  localparam int unsigned FOLD_MAX_W   = 1024;
  localparam int unsigned FOLD_MAX_SIG = 64;
  localparam int unsigned FOLD_IDX_W   = $clog2(FOLD_MAX_SIG);

  // Bit i of the result is the XOR of data[k*sig_width + i] for all k with index < width.
  function automatic logic [FOLD_MAX_SIG-1:0] fold(input logic [FOLD_MAX_W-1:0] data,
                                                   input int unsigned width,
                                                   input int unsigned sig_width);
    logic [FOLD_MAX_SIG-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
      if (i < width) acc[FOLD_IDX_W'(i % sig_width)] ^= data[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/output_signature_compactor_if.sv
// Observed-bus input and serial/parallel signature outputs of the compactor.
interface output_signature_compactor_if #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned SIG_WIDTH = 32
);
  logic                 en;
  logic [WIDTH-1:0]     data_in;
  logic                 sig_bit;
  logic                 sig_valid;
  logic                 sig_last;
  logic [SIG_WIDTH-1:0] sig_word;
  logic [15:0]          window_count;

  modport master (output en, data_in,
                  input  sig_bit, sig_valid, sig_last, sig_word, window_count);
  modport slave  (input  en, data_in,
                  output sig_bit, sig_valid, sig_last, sig_word, window_count);
endinterface

// File: rtl/signature_misr.sv
// Multiple-input signature register: shift-left LFSR with parallel fold injection.
module signature_misr
  import ooc_util_pkg::*;
#(
  parameter int unsigned          SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(CRC32_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED      = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clear,
  input  logic [SIG_WIDTH-1:0] fold_in,
  output logic [SIG_WIDTH-1:0] misr_q,
  output logic [SIG_WIDTH-1:0] misr_next
);

  always_comb begin
    misr_next = {misr_q[SIG_WIDTH-2:0], 1'b0} ^ (misr_q[SIG_WIDTH-1] ? POLY : '0) ^ fold_in;
  end

  // Clear wins over accumulate so a closing window restarts from SEED.
  always_ff @(posedge clk) begin
    if (!reset)      misr_q <= SEED;
    else if (en)     misr_q <= clear ? SEED : misr_next;
  end

endmodule

// File: rtl/output_signature_compactor.sv
// Compacts a wide output bus into a windowed MISR signature and streams each
// snapshot out MSB first with valid/last framing.
module output_signature_compactor
  import ooc_util_pkg::*;
#(
  parameter int unsigned          WIDTH     = 64,
  parameter int unsigned          SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(CRC32_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED      = '0,
  parameter int unsigned          WINDOW    = 1024,
  parameter int unsigned          WCNT_W    = 16,
  parameter bit                   ASSERT_EN = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  output_signature_compactor_if.slave bus
);

  localparam int unsigned    CNT_W    = $clog2(WINDOW);
  localparam int unsigned    IDX_W    = $clog2(SIG_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0]     win_cnt;
  logic [WCNT_W-1:0]    wcnt;
  logic [SIG_WIDTH-1:0] fold_c;
  logic [SIG_WIDTH-1:0] misr_q;
  logic [SIG_WIDTH-1:0] misr_next;
  logic                 close_c;

  shift_state_e         state, state_nxt;
  logic [SIG_WIDTH-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic                 bit_nxt, valid_nxt, last_nxt;

  always_comb begin
    fold_c = SIG_WIDTH'(fold(FOLD_MAX_W'(bus.data_in), WIDTH, SIG_WIDTH));
  end

  assign close_c = bus.en && (win_cnt == LAST_CNT);

  signature_misr #(
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY),
    .SEED      (SEED)
  ) u_misr (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .clear     (close_c),
    .fold_in   (fold_c),
    .misr_q    (misr_q),
    .misr_next (misr_next)
  );

  // Window bookkeeping; the snapshot includes the closing cycle's data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_cnt      <= '0;
      wcnt         <= '0;
      bus.sig_word <= '0;
    end else begin
      if (bus.en) win_cnt <= close_c ? '0 : win_cnt + CNT_W'(1);
      if (close_c) begin
        bus.sig_word <= misr_next;
        if (wcnt != '1) wcnt <= wcnt + WCNT_W'(1);
      end
    end
  end

  assign bus.window_count = 16'(wcnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      shreg         <= '0;
      idx           <= '0;
      bus.sig_bit   <= 1'b0;
      bus.sig_valid <= 1'b0;
      bus.sig_last  <= 1'b0;
    end else begin
      state         <= state_nxt;
      shreg         <= shreg_nxt;
      idx           <= idx_nxt;
      bus.sig_bit   <= bit_nxt;
      bus.sig_valid <= valid_nxt;
      bus.sig_last  <= last_nxt;
    end
  end

  // idx is the position of the bit currently on sig_bit; shreg holds the bits still to go.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    bit_nxt   = 1'b0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    if (close_c) begin
      state_nxt = SHIFT;
      shreg_nxt = {misr_next[SIG_WIDTH-2:0], 1'b0};
      idx_nxt   = IDX_W'(SIG_WIDTH - 1);
      bit_nxt   = misr_next[SIG_WIDTH-1];
      valid_nxt = 1'b1;
    end else if (state == SHIFT) begin
      if (idx == '0) begin
        state_nxt = IDLE;
      end else begin
        bit_nxt   = shreg[SIG_WIDTH-1];
        valid_nxt = 1'b1;
        last_nxt  = (idx == IDX_W'(1));
        shreg_nxt = {shreg[SIG_WIDTH-2:0], 1'b0};
        idx_nxt   = idx - IDX_W'(1);
      end
    end
  end

  a_seed_after_close: assert property (@(posedge clk) disable iff (!reset)
    close_c |=> misr_q == SEED);

  // A close while a frame is still streaming means WINDOW is too short for SIG_WIDTH.
  generate
    if (ASSERT_EN) begin : g_chk
      a_no_close_in_shift: assert property (@(posedge clk) disable iff (!reset)
        !(close_c && state == SHIFT));
    end
  endgenerate

endmodule

// File: tb/tb_output_signature_compactor.sv
// Directed bench for output_signature_compactor: three instances cover the
// nominal window, a short window and a folded 12-bit bus with a narrow counter.
module tb_output_signature_compactor;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  output_signature_compactor_if #(.WIDTH(8),  .SIG_WIDTH(8)) bus_a ();
  output_signature_compactor_if #(.WIDTH(8),  .SIG_WIDTH(8)) bus_b ();
  output_signature_compactor_if #(.WIDTH(12), .SIG_WIDTH(8)) bus_c ();

  output_signature_compactor #(.WIDTH(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00),
    .WINDOW(9)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  output_signature_compactor #(.WIDTH(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00),
    .WINDOW(4), .ASSERT_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  output_signature_compactor #(.WIDTH(12), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00),
    .WINDOW(9), .WCNT_W(4)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.en = 1'b0; bus_a.data_in = '0;
    bus_b.en = 1'b0; bus_b.data_in = '0;
    bus_c.en = 1'b0; bus_c.data_in = '0;
    tick(); tick();
    n_cmp++;
    if ({bus_a.sig_valid, bus_a.sig_bit, bus_a.sig_last, bus_a.sig_word, bus_a.window_count} !== 27'd0) begin
      n_bad++; $display("FAIL reset_a: got v%b b%b l%b w%h c%h want all zero", bus_a.sig_valid,
        bus_a.sig_bit, bus_a.sig_last, bus_a.sig_word, bus_a.window_count);
    end
    n_cmp++;
    if ({bus_b.sig_valid, bus_b.sig_bit, bus_b.sig_last, bus_b.sig_word, bus_b.window_count} !== 27'd0) begin
      n_bad++; $display("FAIL reset_b: got v%b w%h c%h want all zero", bus_b.sig_valid,
        bus_b.sig_word, bus_b.window_count);
    end
    n_cmp++;
    if ({bus_c.sig_valid, bus_c.sig_bit, bus_c.sig_last, bus_c.sig_word, bus_c.window_count} !== 27'd0) begin
      n_bad++; $display("FAIL reset_c: got v%b w%h c%h want all zero", bus_c.sig_valid,
        bus_c.sig_word, bus_c.window_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_window();
    logic [7:0] exp_w;
    exp_w = 8'h00;
    bus_a.en = 1'b1; bus_a.data_in = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (bus_a.sig_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_early_close: sig_valid %b want 0", bus_a.sig_valid);
    end
    tick();
    bus_a.en = 1'b0;
    n_cmp++;
    if (bus_a.sig_word !== exp_w || bus_a.window_count !== 16'd1) begin
      n_bad++; $display("FAIL zero_word: got w%h c%0d want w%h c1", bus_a.sig_word,
        bus_a.window_count, exp_w);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_a.sig_valid, bus_a.sig_bit, bus_a.sig_last} !== {1'b1, exp_w[7-i], i == 7}) begin
        n_bad++; $display("FAIL zero_frame bit%0d: got v%b b%b l%b want v1 b%b l%b", i,
          bus_a.sig_valid, bus_a.sig_bit, bus_a.sig_last, exp_w[7-i], i == 7);
      end
      tick();
    end
    n_cmp++;
    if (bus_a.sig_valid !== 1'b0 || bus_a.sig_last !== 1'b0) begin
      n_bad++; $display("FAIL zero_frame_end: v%b l%b want v0 l0", bus_a.sig_valid, bus_a.sig_last);
    end
  endtask

  task automatic test_ones_short_window();
    logic [7:0] exp_w;
    exp_w = 8'h0F;
    bus_b.en = 1'b1; bus_b.data_in = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    bus_b.en = 1'b0; bus_b.data_in = 8'h00;
    n_cmp++;
    if (bus_b.sig_word !== exp_w || bus_b.window_count !== 16'd1) begin
      n_bad++; $display("FAIL ones_word: got w%h c%0d want w%h c1", bus_b.sig_word,
        bus_b.window_count, exp_w);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_b.sig_valid, bus_b.sig_bit, bus_b.sig_last} !== {1'b1, exp_w[7-i], i == 7}) begin
        n_bad++; $display("FAIL ones_frame bit%0d: got v%b b%b l%b want v1 b%b l%b", i,
          bus_b.sig_valid, bus_b.sig_bit, bus_b.sig_last, exp_w[7-i], i == 7);
      end
      tick();
    end
    n_cmp++;
    if (bus_b.sig_valid !== 1'b0) begin
      n_bad++; $display("FAIL ones_frame_end: v%b want 0", bus_b.sig_valid);
    end
  endtask

  task automatic test_impulse();
    logic [7:0] exp_w;
    exp_w = 8'h74;
    bus_b.en = 1'b1; bus_b.data_in = 8'h80;
    tick();
    bus_b.data_in = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    bus_b.en = 1'b0;
    n_cmp++;
    if (bus_b.sig_word !== exp_w || bus_b.window_count !== 16'd2) begin
      n_bad++; $display("FAIL impulse_word: got w%h c%0d want w%h c2", bus_b.sig_word,
        bus_b.window_count, exp_w);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_b.sig_valid, bus_b.sig_bit, bus_b.sig_last} !== {1'b1, exp_w[7-i], i == 7}) begin
        n_bad++; $display("FAIL impulse_frame bit%0d: got v%b b%b l%b want v1 b%b l%b", i,
          bus_b.sig_valid, bus_b.sig_bit, bus_b.sig_last, exp_w[7-i], i == 7);
      end
      tick();
    end
  endtask

  // en=0 cycles carry 8'hFF which must not disturb the signature or the count.
  task automatic test_gapped_enable();
    logic [7:0] exp_w;
    exp_w = 8'hE2;
    for (int j = 0; j < 8; j++) begin
      bus_a.en = 1'b1; bus_a.data_in = 8'h01; tick();
      bus_a.en = 1'b0; bus_a.data_in = 8'hFF; tick();
    end
    n_cmp++;
    if (bus_a.sig_valid !== 1'b0 || bus_a.window_count !== 16'd1) begin
      n_bad++; $display("FAIL gapped_early_close: v%b c%0d want v0 c1", bus_a.sig_valid,
        bus_a.window_count);
    end
    bus_a.en = 1'b1; bus_a.data_in = 8'h01; tick();
    bus_a.en = 1'b0; bus_a.data_in = 8'hFF;
    n_cmp++;
    if (bus_a.sig_word !== exp_w || bus_a.window_count !== 16'd2) begin
      n_bad++; $display("FAIL gapped_word: got w%h c%0d want w%h c2", bus_a.sig_word,
        bus_a.window_count, exp_w);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_a.sig_valid, bus_a.sig_bit, bus_a.sig_last} !== {1'b1, exp_w[7-i], i == 7}) begin
        n_bad++; $display("FAIL gapped_frame bit%0d: got v%b b%b l%b want v1 b%b l%b", i,
          bus_a.sig_valid, bus_a.sig_bit, bus_a.sig_last, exp_w[7-i], i == 7);
      end
      tick();
    end
    bus_a.data_in = 8'h00;
  endtask

  task automatic test_reset_mid_frame();
    bus_a.en = 1'b1; bus_a.data_in = 8'h01;
    for (int i = 0; i < 9; i++) tick();
    bus_a.en = 1'b0;
    tick(); tick();
    n_cmp++;
    if (bus_a.sig_valid !== 1'b1) begin
      n_bad++; $display("FAIL midreset_in_frame: v%b want 1", bus_a.sig_valid);
    end
    reset = 1'b0; tick(); reset = 1'b1;
    n_cmp++;
    if (bus_a.sig_valid !== 1'b0 || bus_a.sig_word !== 8'h00 || bus_a.window_count !== 16'd0) begin
      n_bad++; $display("FAIL midreset_clear: got v%b w%h c%0d want v0 w00 c0", bus_a.sig_valid,
        bus_a.sig_word, bus_a.window_count);
    end
    tick(); tick();
    n_cmp++;
    if (bus_a.sig_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_no_resume: v%b want 0", bus_a.sig_valid);
    end
    bus_a.en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (bus_a.sig_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_fresh_count: v%b after 8 cycles want 0", bus_a.sig_valid);
    end
    tick();
    bus_a.en = 1'b0;
    n_cmp++;
    if (bus_a.sig_valid !== 1'b1 || bus_a.sig_word !== 8'hE2 || bus_a.window_count !== 16'd1) begin
      n_bad++; $display("FAIL midreset_next_window: got v%b w%h c%0d want v1 wE2 c1",
        bus_a.sig_valid, bus_a.sig_word, bus_a.window_count);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  // 12-bit bus folds into 8 bits with bits [11:8] landing on [3:0].
  task automatic test_fold();
    logic [7:0] exp_w;
    exp_w = 8'hA6;
    bus_c.en = 1'b1; bus_c.data_in = 12'hF01;
    tick();
    bus_c.data_in = 12'h000;
    for (int i = 0; i < 8; i++) tick();
    bus_c.en = 1'b0;
    n_cmp++;
    if (bus_c.sig_word !== exp_w || bus_c.window_count !== 16'd1) begin
      n_bad++; $display("FAIL fold_word: got w%h c%0d want w%h c1", bus_c.sig_word,
        bus_c.window_count, exp_w);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_c.sig_valid, bus_c.sig_bit, bus_c.sig_last} !== {1'b1, exp_w[7-i], i == 7}) begin
        n_bad++; $display("FAIL fold_frame bit%0d: got v%b b%b l%b want v1 b%b l%b", i,
          bus_c.sig_valid, bus_c.sig_bit, bus_c.sig_last, exp_w[7-i], i == 7);
      end
      tick();
    end
  endtask

  // dut_c has a 4-bit window counter, so it saturates at 15 rather than 16'hFFFF.
  task automatic test_back_to_back();
    bus_c.en = 1'b1; bus_c.data_in = 12'h000;
    for (int i = 0; i < 13 * 9; i++) tick();
    n_cmp++;
    if (bus_c.window_count !== 16'd14 || bus_c.sig_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_count14: got c%0d v%b want c14 v1", bus_c.window_count,
        bus_c.sig_valid);
    end
    for (int i = 0; i < 3 * 9; i++) tick();
    bus_c.en = 1'b0;
    n_cmp++;
    if (bus_c.window_count !== 16'd15) begin
      n_bad++; $display("FAIL b2b_saturate: got c%0d want 15", bus_c.window_count);
    end
    n_cmp++;
    if (bus_c.sig_valid !== 1'b1 || bus_c.sig_word !== 8'h00) begin
      n_bad++; $display("FAIL b2b_frame_after_sat: got v%b w%h want v1 w00", bus_c.sig_valid,
        bus_c.sig_word);
    end
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (bus_c.sig_last !== 1'b1) begin
      n_bad++; $display("FAIL b2b_last: l%b want 1", bus_c.sig_last);
    end
    tick();
    n_cmp++;
    if (bus_c.sig_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_frame_end: v%b want 0", bus_c.sig_valid);
    end
  endtask

  initial begin
    test_reset();
    test_zero_window();
    test_ones_short_window();
    test_impulse();
    test_gapped_enable();
    test_reset_mid_frame();
    test_fold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/output_signature_compactor.md
Name: output_signature_compactor

Overview:
- Response-side counterpart to the OOC random-stimulus generator. It consumes a wide design output bus, such as the 64-bit des3_perf output, every cycle.
- It compacts the bus into a multiple-input signature register (MISR) over a fixed window of cycles.
- At the end of each window it snapshots the signature and emits it serially on a single pin, with a valid/last framing.
- The result is that a few top-level pins observe every output bit, so synthesis cannot prune the design logic.

Parameters:
- WIDTH, 64, width of the observed data bus.
- SIG_WIDTH, 32, MISR/signature width; must satisfy 2 <= SIG_WIDTH.
- POLY, 32'h04C11DB7, feedback polynomial as a SIG_WIDTH-bit mask (bit i set = tap into bit i).
- SEED, 32'h0000_0000, MISR value after reset and after each window close.
- WINDOW, 1024, cycles of enabled input per signature; must satisfy WINDOW >= SIG_WIDTH + 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- en  in  1  accumulate data_in this cycle.
- data_in  in  WIDTH  observed design output.
- sig_bit  out  1  serial signature bit, MSB first.
- sig_valid  out  1  sig_bit is meaningful this cycle.
- sig_last  out  1  high with the final (LSB) bit of a frame.
- sig_word  out  SIG_WIDTH  parallel copy of the most recent snapshot.
- window_count  out  16  completed windows, saturating at 16'hFFFF.

Behaviour:
- Reset values (reset==0 at a clock edge):
  - MISR = SEED; window counter = 0.
  - shifter state = IDLE; sig_bit = 0, sig_valid = 0, sig_last = 0.
  - sig_word = 0; window_count = 0.
  - Reset asserted mid-window or mid-shift aborts everything. No partial frame is ever completed.
- Fold definition:
  - fold[i] = XOR over all k of data_in[k*SIG_WIDTH + i], taking only indices < WIDTH.
  - Missing high bits are treated as zero.
- MISR update when en==1:
  - next = {misr[SIG_WIDTH-2:0],1'b0} ^ (misr[SIG_WIDTH-1] ? POLY : 0) ^ fold.
- Cycles with en==0:
  - MISR and window counter hold.
  - Input is ignored.
- Window counter:
  - Increments on en==1 cycles, running 0..WINDOW-1.
  - On an en==1 cycle with counter==WINDOW-1 the window closes:
    - snapshot = next (this cycle's data is included);
    - sig_word <= snapshot; window_count increments (saturating);
    - MISR <= SEED; counter <= 0.
- Accumulation is continuous. The next window begins on the cycle after close, independent of the shifter.
- Shifter FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on window close. The shift register loads the snapshot and the bit index is set to SIG_WIDTH-1.
  - In SHIFT, registered outputs are sig_valid=1 and sig_bit=shreg[SIG_WIDTH-1]. The register shifts left each cycle.
  - sig_last=1 on the SIG_WIDTH-th bit, after which the FSM returns to IDLE.
  - SHIFT ignores en; the frame is never stalled.
  - Close-to-first-bit latency is 1 cycle: the first bit is visible the cycle after the closing edge. A frame is exactly SIG_WIDTH consecutive valid cycles.
  - WINDOW >= SIG_WIDTH+1 guarantees a close never occurs in SHIFT.
  - If a close does arrive in SHIFT (parameter misuse), the shifter reloads and restarts the frame. A simulation assertion must flag this.
- Outputs are registered; none is combinational from data_in or en.

Decomposition:
- Shared package ooc_util_pkg holds:
  - shifter state enum (IDLE, SHIFT);
  - default polynomial constants CRC32_POLY and CRC16_POLY;
  - a fold function parameterised by WIDTH/SIG_WIDTH.
- One sub-module, signature_misr (parameters SIG_WIDTH, POLY, SEED; ports clk, reset, en, clear, fold_in, misr_q, misr_next), holds the MISR register.
- The top level holds the window counter, the snapshot logic, and the serial shifter FSM.

Test Plan (WIDTH=8, SIG_WIDTH=8, POLY=8'h1D, SEED=0, WINDOW=9 unless noted):
- data_in=8'h00, en=1 for 9 cycles -> sig_word=8'h00; 8 valid bits all 0; sig_last on the 8th; window_count=1.
- WINDOW=4 (assertion disabled), data_in=8'h01 held 4 cycles -> MISR 01,03,07,0F; sig_word=8'h0F; serial bits 0,0,0,0,1,1,1,1.
- WINDOW=4 (assertion disabled), data_in=8'h80 in the first cycle then 8'h00 -> MISR 80,1D,3A,74; sig_word=8'h74.
- en toggled 1,0,1,0,... with data 8'h01 on en=1 cycles (data 8'hFF while en=0) -> signature equals the 9-cycle contiguous 8'h01 run; close occurs on the 9th en=1 cycle.
- reset=0 for 1 cycle during the 3rd bit of a frame -> sig_valid=0 next cycle; sig_word=0; window_count=0; the following window counts 9 fresh enabled cycles.
- 70000 windows back-to-back -> window_count saturates at 16'hFFFF; frames continue normally.
